branch_predict: RTL and testbench

BRANCH_PREDICT -- requirements
Module: branch_predict

---
 rtl/branch_predict_pkg.sv | 38 +++
 rtl/branch_predict_pht_table.sv | 46 ++++
 rtl/branch_predict.sv | 88 ++++++++
 tb/tb_branch_predict.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_pkg.sv
// Shared defines: execute-stage op codes, predictor counter encodings and default sizes.
package branch_predict_pkg;

    // Execute-stage operation codes used by the branch judge.
    localparam logic [7:0] EXE_NOP_OP  = 8'h00;
    localparam logic [7:0] EXE_BEQ_OP  = 8'h01;
    localparam logic [7:0] EXE_BNE_OP  = 8'h02;
    localparam logic [7:0] EXE_BLEZ_OP = 8'h03;
    localparam logic [7:0] EXE_BGTZ_OP = 8'h04;
    localparam logic [7:0] EXE_BLTZ_OP = 8'h05;
    localparam logic [7:0] EXE_BGEZ_OP = 8'h06;

    // Default PHT index width, which is also the global history length.
    localparam int DEF_IDX_W = 10;

    // 2-bit saturating direction counter; MSB is the predicted direction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    // Move one step toward the resolved direction, sticking at the ends.
    function automatic cnt_e sat_update(input cnt_e cur, input logic taken);
        cnt_e nxt;
        nxt = cur;
        case (cur)
            SNT: nxt = taken ? WNT : SNT;
            WNT: nxt = taken ? WT  : SNT;
            WT:  nxt = taken ? ST  : WNT;
            ST:  nxt = taken ? ST  : WT;
            default: nxt = WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predict_pht_table.sv
// Pattern history table: 2^IDX_W saturating counters, one read port with
// write-through bypass and one update port.
module pht_table
    import branch_predict_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [IDX_W-1:0] rd_idx,
    output cnt_e             rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int DEPTH = 1 << IDX_W;

    cnt_e pht [DEPTH];
    cnt_e wr_next;

    // Post-update value of the entry being trained this cycle.
    always_comb begin
        wr_next = sat_update(pht[wr_idx], wr_taken);
    end

    // Read port: a lookup of the entry being trained sees the new value.
    always_comb begin
        rd_cnt = pht[rd_idx];
        if (wr_en && (wr_idx == rd_idx)) begin
            rd_cnt = wr_next;
        end
    end

    // Counter storage; every entry starts weakly not-taken.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht[i] <= WNT;
            end
        end else if (wr_en) begin
            pht[wr_idx] <= wr_next;
        end
    end

endmodule

// File: rtl/branch_predict.sv
// Gshare direction predictor: fetch-stage lookup registered into D,
// non-speculative history trained from E, plus branch/mispredict counters.
module branch_predict
    import branch_predict_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [31:0]      pcF,
    input  logic             stallD,
    input  logic             flushD,
    output logic             pred_takeD,
    output logic [IDX_W-1:0] pht_idxD,
    input  logic             branchE,
    input  logic [IDX_W-1:0] pht_idxE,
    input  logic             pred_takeE,
    input  logic             actual_takeE,
    output logic             mispredictE,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    logic [IDX_W-1:0] ghr;
    logic [IDX_W-1:0] idxF;
    cnt_e             rd_cnt;
    logic             unused_pc_bits;

    // Only the word-address bits below the index width feed the hash.
    assign unused_pc_bits = ^{pcF[31:IDX_W+2], pcF[1:0]};

    // Lookup hash uses the history as it stands before this cycle's update.
    assign idxF = pcF[IDX_W+1:2] ^ ghr;

    assign mispredictE = branchE & (pred_takeE ^ actual_takeE);

    pht_table #(
        .IDX_W (IDX_W)
    ) u_pht (
        .clk      (clk),
        .resetn   (resetn),
        .rd_idx   (idxF),
        .rd_cnt   (rd_cnt),
        .wr_en    (branchE),
        .wr_idx   (pht_idxE),
        .wr_taken (actual_takeE)
    );

    // Global history shifts in each resolved outcome.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ghr <= '0;
        end else if (branchE) begin
            ghr <= {ghr[IDX_W-2:0], actual_takeE};
        end
    end

    // D-stage prediction registers; flush wins over stall.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pred_takeD <= 1'b0;
            pht_idxD   <= '0;
        end else if (flushD) begin
            pred_takeD <= 1'b0;
            pht_idxD   <= '0;
        end else if (!stallD) begin
            pred_takeD <= rd_cnt[1];
            pht_idxD   <= idxF;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (branchE && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + 1'b1;
            end
            if (mispredictE && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predict.sv
// Directed bench for branch_predict with a 4-bit counter width so that
// counter saturation is reachable.
module tb_branch_predict;

    localparam int IDX_W = 10;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             resetn;
    logic [31:0]      pcF;
    logic             stallD;
    logic             flushD;
    logic             pred_takeD;
    logic [IDX_W-1:0] pht_idxD;
    logic             branchE;
    logic [IDX_W-1:0] pht_idxE;
    logic             pred_takeE;
    logic             actual_takeE;
    logic             mispredictE;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    int passed = 0;
    int total  = 0;

    // Bench copy of the global history, advanced by hand at each update.
    logic [IDX_W-1:0] g;

    branch_predict #(
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .pcF          (pcF),
        .stallD       (stallD),
        .flushD       (flushD),
        .pred_takeD   (pred_takeD),
        .pht_idxD     (pht_idxD),
        .branchE      (branchE),
        .pht_idxE     (pht_idxE),
        .pred_takeE   (pred_takeE),
        .actual_takeE (actual_takeE),
        .mispredictE  (mispredictE),
        .branch_cnt   (branch_cnt),
        .mispred_cnt  (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // PC whose hash with the current modelled history lands on idx.
    function automatic logic [31:0] pc_for(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] h;
        h = idx ^ g;
        return {20'b0, h, 2'b00};
    endfunction

    task automatic update(input logic [IDX_W-1:0] idx, input logic pe, input logic ae);
        branchE      = 1'b1;
        pht_idxE     = idx;
        pred_takeE   = pe;
        actual_takeE = ae;
    endtask

    initial begin
        resetn = 1'b0; pcF = 32'h0; stallD = 1'b0; flushD = 1'b0;
        branchE = 1'b0; pht_idxE = '0; pred_takeE = 1'b0; actual_takeE = 1'b0;
        g = '0;

        // Reset state
        tick(); tick();
        check("rst_pred", {31'b0, pred_takeD}, 32'h0);
        check("rst_idx", {22'b0, pht_idxD}, 32'h0);
        check("rst_bcnt", {28'b0, branch_cnt}, 32'h0);
        check("rst_mcnt", {28'b0, mispred_cnt}, 32'h0);
        resetn = 1'b1;

        // First lookup after reset
        pcF = 32'h0000_0040;
        tick();
        check("first_idx", {22'b0, pht_idxD}, 32'h010);
        check("first_pred", {31'b0, pred_takeD}, 32'h0);

        // Two taken updates at 0x010 (01 -> 10 -> 11), both mispredicted
        update(10'h010, 1'b0, 1'b1);
        #1 check("misp_comb_1", {31'b0, mispredictE}, 32'h1);
        tick(); g = {g[IDX_W-2:0], 1'b1};
        tick(); g = {g[IDX_W-2:0], 1'b1};
        branchE = 1'b0;
        pcF = 32'h0000_0040;
        tick();
        check("ghr3_idx", {22'b0, pht_idxD}, 32'h013);
        check("ghr3_pred", {31'b0, pred_takeD}, 32'h0);
        pcF = pc_for(10'h010);
        tick();
        check("st_idx", {22'b0, pht_idxD}, 32'h010);
        check("st_pred", {31'b0, pred_takeD}, 32'h1);
        check("cnt_b2", {28'b0, branch_cnt}, 32'h2);
        check("cnt_m2", {28'b0, mispred_cnt}, 32'h2);

        // Bypass: train 0x013 from 01 to 10 while looking it up
        update(10'h013, 1'b1, 1'b1);
        pcF = pc_for(10'h013);
        #1 check("misp_comb_0", {31'b0, mispredictE}, 32'h0);
        tick(); g = {g[IDX_W-2:0], 1'b1};
        check("byp_idx", {22'b0, pht_idxD}, 32'h013);
        check("byp_pred", {31'b0, pred_takeD}, 32'h1);

        // Not-taken run from ST at 0x010: 10, 01, 00, 00 seen through bypass MSB
        update(10'h010, 1'b0, 1'b0);
        pcF = pc_for(10'h010); tick(); g = {g[IDX_W-2:0], 1'b0};
        check("nt1_pred", {31'b0, pred_takeD}, 32'h1);
        pcF = pc_for(10'h010); tick(); g = {g[IDX_W-2:0], 1'b0};
        check("nt2_pred", {31'b0, pred_takeD}, 32'h0);
        pcF = pc_for(10'h010); tick(); g = {g[IDX_W-2:0], 1'b0};
        check("nt3_pred", {31'b0, pred_takeD}, 32'h0);
        pcF = pc_for(10'h010); tick(); g = {g[IDX_W-2:0], 1'b0};
        check("nt4_pred", {31'b0, pred_takeD}, 32'h0);
        check("nt4_idx", {22'b0, pht_idxD}, 32'h010);
        // From 00, two taken steps are needed before the MSB sets
        update(10'h010, 1'b1, 1'b1);
        pcF = pc_for(10'h010); tick(); g = {g[IDX_W-2:0], 1'b1};
        check("sat_t1_pred", {31'b0, pred_takeD}, 32'h0);
        pcF = pc_for(10'h010); tick(); g = {g[IDX_W-2:0], 1'b1};
        check("sat_t2_pred", {31'b0, pred_takeD}, 32'h1);
        check("cnt_b9", {28'b0, branch_cnt}, 32'h9);
        check("cnt_m2b", {28'b0, mispred_cnt}, 32'h2);

        // Stall and flush together clear D; the update still lands
        update(10'h020, 1'b1, 1'b1);
        stallD = 1'b1; flushD = 1'b1;
        pcF = pc_for(10'h010);
        tick(); g = {g[IDX_W-2:0], 1'b1};
        check("flush_pred", {31'b0, pred_takeD}, 32'h0);
        check("flush_idx", {22'b0, pht_idxD}, 32'h0);
        branchE = 1'b0; stallD = 1'b0; flushD = 1'b0;
        pcF = pc_for(10'h020);
        tick();
        check("flush_upd_pred", {31'b0, pred_takeD}, 32'h1);
        check("flush_upd_idx", {22'b0, pht_idxD}, 32'h020);

        // Stall alone holds D
        stallD = 1'b1;
        pcF = pc_for(10'h013) ^ 32'h0000_0100;
        tick();
        check("stall_idx", {22'b0, pht_idxD}, 32'h020);
        check("stall_pred", {31'b0, pred_takeD}, 32'h1);
        stallD = 1'b0;

        // Mispredict: predicted taken, resolved not taken
        update(10'h100, 1'b1, 1'b0);
        #1 check("misp_comb_2", {31'b0, mispredictE}, 32'h1);
        tick(); g = {g[IDX_W-2:0], 1'b0};
        check("misp_bcnt", {28'b0, branch_cnt}, 32'hB);
        check("misp_mcnt", {28'b0, mispred_cnt}, 32'h3);
        branchE = 1'b0;
        #1 check("misp_nobr", {31'b0, mispredictE}, 32'h0);

        // Drive both counters into saturation
        update(10'h100, 1'b1, 1'b0);
        for (int i = 0; i < 13; i++) begin
            tick(); g = {g[IDX_W-2:0], 1'b0};
        end
        check("sat_bcnt", {28'b0, branch_cnt}, 32'hF);
        check("sat_mcnt", {28'b0, mispred_cnt}, 32'hF);

        // Load a taken prediction into D ahead of the reset pulse
        branchE = 1'b0;
        pcF = pc_for(10'h020);
        tick();
        check("pre_rst_pred", {31'b0, pred_takeD}, 32'h1);

        // Reset asserted mid-cycle with an update pending; that update is dropped
        update(10'h010, 1'b0, 1'b1);
        resetn = 1'b0;
        #1;
        check("arst_pred", {31'b0, pred_takeD}, 32'h0);
        check("arst_idx", {22'b0, pht_idxD}, 32'h0);
        check("arst_bcnt", {28'b0, branch_cnt}, 32'h0);
        check("arst_mcnt", {28'b0, mispred_cnt}, 32'h0);
        tick();
        branchE = 1'b0;
        resetn = 1'b1;
        g = '0;
        pcF = 32'h0000_0080;
        tick();
        check("post_rst_020_idx", {22'b0, pht_idxD}, 32'h020);
        check("post_rst_020_pred", {31'b0, pred_takeD}, 32'h0);

        // First edge after release trains normally (01 -> 10, seen via bypass)
        update(10'h010, 1'b0, 1'b1);
        pcF = 32'h0000_0040;
        tick(); g = {g[IDX_W-2:0], 1'b1};
        check("post_rst_idx", {22'b0, pht_idxD}, 32'h010);
        check("post_rst_pred", {31'b0, pred_takeD}, 32'h1);
        check("post_rst_bcnt", {28'b0, branch_cnt}, 32'h1);
        check("post_rst_mcnt", {28'b0, mispred_cnt}, 32'h1);
        branchE = 1'b0;
        pcF = 32'h0000_0040;
        tick();
        check("post_rst_ghr_idx", {22'b0, pht_idxD}, 32'h011);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
